// File: rtl/burp_pkg.sv
// Shared definitions for the BURP 4-bit sequencer: opcodes, FSM states,
// 74181 control constants, decoder bundle and register-select helper.
package burp_pkg;

  localparam int NUM_REGS = 10;
  localparam logic [3:0] MAX_REG = 4'd9;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_STR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_IN  = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JC  = 4'hD;
  localparam logic [3:0] OP_RSV = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef logic [2:0] state_t;
  localparam state_t ST_FETCH = 3'd0;
  localparam state_t ST_OPND  = 3'd1;
  localparam state_t ST_EXEC  = 3'd2;
  localparam state_t ST_WB    = 3'd3;
  localparam state_t ST_HALT  = 3'd4;

  // 74181 select/mode/carry per operation (carry is active low)
  localparam logic [3:0] ALU_S_IDLE = 4'b0000;
  localparam logic       ALU_M_IDLE = 1'b0;
  localparam logic       ALU_CN_IDLE = 1'b1;
  localparam logic [3:0] ALU_S_ADD = 4'b1001;
  localparam logic       ALU_M_ADD = 1'b0;
  localparam logic       ALU_CN_ADD = 1'b1;
  localparam logic [3:0] ALU_S_SUB = 4'b0110;
  localparam logic       ALU_M_SUB = 1'b0;
  localparam logic       ALU_CN_SUB = 1'b0;
  localparam logic [3:0] ALU_S_PASS = 4'b1010;
  localparam logic [3:0] ALU_S_AND = 4'b1011;
  localparam logic [3:0] ALU_S_OR  = 4'b1110;
  localparam logic [3:0] ALU_S_XOR = 4'b0110;
  localparam logic       ALU_M_LOGIC = 1'b1;
  localparam logic       ALU_CN_LOGIC = 1'b1;

  // flag_mask bit order is {C, Z}
  localparam logic [1:0] FLAGS_NONE = 2'b00;
  localparam logic [1:0] FLAGS_Z    = 2'b01;
  localparam logic [1:0] FLAGS_ZC   = 2'b11;

  typedef struct packed {
    logic [3:0] s;
    logic       m;
    logic       cn;
    logic       is_branch;
    logic       writes_acc;
    logic       writes_reg;
    logic [1:0] flag_mask;
    logic       illegal;
  } ctrl_t;

  function automatic logic [NUM_REGS-1:0] reg_sel(input logic [3:0] n);
    logic [NUM_REGS-1:0] sel;
    sel = '0;
    if (n <= MAX_REG) sel[n] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/burp_decoder.sv
// Combinational instruction decoder: ir -> 74181 controls, flag mask,
// branch/accumulator/register-write strobes and illegal-index flag.
module burp_decoder
  import burp_pkg::*;
(
  input  logic [7:0] ir,
  output ctrl_t      ctrl
);

  logic [3:0] op;
  logic [3:0] n;
  logic       uses_reg;

  assign op = ir[7:4];
  assign n  = ir[3:0];
  assign uses_reg = (op >= OP_MOV) && (op <= OP_XOR);

  always_comb begin
    ctrl    = '0;
    ctrl.s  = ALU_S_IDLE;
    ctrl.m  = ALU_M_IDLE;
    ctrl.cn = ALU_CN_IDLE;
    unique case (op)
      OP_LDI, OP_IN: ctrl.writes_acc = 1'b1;
      OP_MOV: begin
        ctrl.s          = ALU_S_PASS;
        ctrl.m          = ALU_M_LOGIC;
        ctrl.cn         = ALU_CN_LOGIC;
        ctrl.writes_acc = 1'b1;
        ctrl.flag_mask  = FLAGS_Z;
      end
      OP_STR: ctrl.writes_reg = 1'b1;
      OP_ADD: begin
        ctrl.s          = ALU_S_ADD;
        ctrl.m          = ALU_M_ADD;
        ctrl.cn         = ALU_CN_ADD;
        ctrl.writes_acc = 1'b1;
        ctrl.flag_mask  = FLAGS_ZC;
      end
      OP_SUB: begin
        ctrl.s          = ALU_S_SUB;
        ctrl.m          = ALU_M_SUB;
        ctrl.cn         = ALU_CN_SUB;
        ctrl.writes_acc = 1'b1;
        ctrl.flag_mask  = FLAGS_ZC;
      end
      OP_AND: begin
        ctrl.s          = ALU_S_AND;
        ctrl.m          = ALU_M_LOGIC;
        ctrl.cn         = ALU_CN_LOGIC;
        ctrl.writes_acc = 1'b1;
        ctrl.flag_mask  = FLAGS_Z;
      end
      OP_OR: begin
        ctrl.s          = ALU_S_OR;
        ctrl.m          = ALU_M_LOGIC;
        ctrl.cn         = ALU_CN_LOGIC;
        ctrl.writes_acc = 1'b1;
        ctrl.flag_mask  = FLAGS_Z;
      end
      OP_XOR: begin
        ctrl.s          = ALU_S_XOR;
        ctrl.m          = ALU_M_LOGIC;
        ctrl.cn         = ALU_CN_LOGIC;
        ctrl.writes_acc = 1'b1;
        ctrl.flag_mask  = FLAGS_Z;
      end
      OP_JMP, OP_JZ, OP_JC: ctrl.is_branch = 1'b1;
      default: ;
    endcase
    // A register index past R9 turns the whole instruction into a NOP.
    if (uses_reg && (n > MAX_REG)) begin
      ctrl         = '0;
      ctrl.s       = ALU_S_IDLE;
      ctrl.m       = ALU_M_IDLE;
      ctrl.cn      = ALU_CN_IDLE;
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/burp_sequencer.sv
// BURP fetch/decode/execute controller: pc, acc, Z/C flags, EEPROM address,
// register-file selects, 74181 controls and I/O. Optional BURP_SEQ_STEP_EN
// adds a `step` input that gates FETCH to run one instruction per pulse.
// Ports: clk/rst, address/eeprom_data, Gr/Sr/wb_data/reg_q, bus_a/S/Mode/
// CYin/alu_f/CYout, IN_port/OUT_wire, halted, err (sticky), step (optional).
module burp_sequencer
  import burp_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  output logic [7:0]          address,
  input  logic [7:0]          eeprom_data,
  output logic [NUM_REGS-1:0] Gr,
  output logic [NUM_REGS-1:0] Sr,
  output logic [3:0]          wb_data,
  input  logic [3:0]          reg_q,
  output logic [3:0]          bus_a,
  output logic [3:0]          S,
  output logic                Mode,
  output logic                CYin,
  input  logic [3:0]          alu_f,
  input  logic                CYout,
  input  logic [3:0]          IN_port,
  output logic [3:0]          OUT_wire,
  output logic                halted,
  output logic                err
`ifdef BURP_SEQ_STEP_EN
  ,
  input  logic                step
`endif
);

  state_t     state;
  logic [7:0] pc;
  logic [7:0] ir;
  logic [7:0] tgt;
  logic [3:0] acc;
  logic       z_flag;
  logic       c_flag;
  logic [3:0] out_reg;
  logic       err_reg;

  ctrl_t      ctrl;
  logic [3:0] op;
  logic [3:0] n;
  logic [3:0] fetch_op;
  logic [3:0] acc_next;
  logic       take;
  logic       exec;
  logic       go;

  assign op       = ir[7:4];
  assign n        = ir[3:0];
  assign fetch_op = eeprom_data[7:4];

`ifdef BURP_SEQ_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif

  burp_decoder u_dec (
    .ir   (ir),
    .ctrl (ctrl)
  );

  // MOV takes Rn straight from bus B; the ALU is set to pass B anyway.
  always_comb begin
    acc_next = alu_f;
    unique case (op)
      OP_LDI:  acc_next = n;
      OP_MOV:  acc_next = reg_q;
      OP_IN:   acc_next = IN_port;
      default: acc_next = alu_f;
    endcase
  end

  always_comb begin
    take = 1'b0;
    unique case (op)
      OP_JMP:  take = 1'b1;
      OP_JZ:   take = z_flag;
      OP_JC:   take = c_flag;
      default: take = 1'b0;
    endcase
  end

  // Selects drop as soon as rst is seen, so a WB cut by reset never writes.
  assign exec = (state == ST_EXEC) && !rst;

  // Only MOV and the ALU ops update Z, and exactly they read bus B.
  assign Gr   = (exec && ctrl.flag_mask[0]) ? reg_sel(n) : '0;
  assign Sr   = ((state == ST_WB) && !rst) ? reg_sel(n) : '0;
  assign S    = exec ? ctrl.s  : ALU_S_IDLE;
  assign Mode = exec ? ctrl.m  : ALU_M_IDLE;
  assign CYin = exec ? ctrl.cn : ALU_CN_IDLE;

  assign address  = pc;
  assign wb_data  = acc;
  assign bus_a    = acc;
  assign OUT_wire = out_reg;
  assign halted   = (state == ST_HALT);
  assign err      = err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      tgt     <= '0;
      acc     <= '0;
      z_flag  <= 1'b0;
      c_flag  <= 1'b0;
      out_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      unique case (state)
        ST_FETCH: begin
          if (go) begin
            ir <= eeprom_data;
            pc <= pc + 8'd1;
            unique case (1'b1)
              fetch_op == OP_HLT: state <= ST_HALT;
              fetch_op == OP_JMP,
              fetch_op == OP_JZ,
              fetch_op == OP_JC: state <= ST_OPND;
              default: state <= ST_EXEC;
            endcase
          end
        end
        ST_OPND: begin
          tgt   <= eeprom_data;
          pc    <= pc + 8'd1;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (ctrl.illegal) err_reg <= 1'b1;
          if (ctrl.writes_acc) acc <= acc_next;
          if (ctrl.flag_mask[0]) z_flag <= (acc_next == 4'd0);
          if (ctrl.flag_mask[1]) c_flag <= ~CYout;
          if (op == OP_OUT) out_reg <= acc;
          if (ctrl.is_branch && take) pc <= tgt;
          state <= ctrl.writes_reg ? ST_WB : ST_FETCH;
        end
        ST_WB:   state <= ST_FETCH;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_burp_sequencer.sv
// Self-checking bench for burp_sequencer: EEPROM and register-file models,
// a per-cycle vector table for a main program, and directed corner cases.
module tb_burp_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] address;
  logic [7:0] eeprom_data;
  logic [9:0] Gr;
  logic [9:0] Sr;
  logic [3:0] wb_data;
  logic [3:0] reg_q;
  logic [3:0] bus_a;
  logic [3:0] S;
  logic       Mode;
  logic       CYin;
  logic [3:0] alu_f;
  logic       CYout;
  logic [3:0] IN_port;
  logic [3:0] OUT_wire;
  logic       halted;
  logic       err;
`ifdef BURP_SEQ_STEP_EN
  logic       step;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] rom [256];
  logic [3:0] regs [10] = '{default: 4'h0};

  always #5 clk = ~clk;

  burp_sequencer #(.RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .address     (address),
    .eeprom_data (eeprom_data),
    .Gr          (Gr),
    .Sr          (Sr),
    .wb_data     (wb_data),
    .reg_q       (reg_q),
    .bus_a       (bus_a),
    .S           (S),
    .Mode        (Mode),
    .CYin        (CYin),
    .alu_f       (alu_f),
    .CYout       (CYout),
    .IN_port     (IN_port),
    .OUT_wire    (OUT_wire),
    .halted      (halted),
    .err         (err)
`ifdef BURP_SEQ_STEP_EN
    ,
    .step        (step)
`endif
  );

  assign eeprom_data = rom[address];

  always_comb begin
    reg_q = 4'h0;
    for (int i = 0; i < 10; i++)
      if (Gr[i]) reg_q = regs[i];
  end

  always @(posedge clk)
    for (int i = 0; i < 10; i++)
      if (Sr[i]) regs[i] <= wb_data;

  typedef struct {
    logic [3:0] afn;
    logic       cyo;
    logic [7:0] adr;
    logic [9:0] gr;
    logic [9:0] sr;
    logic [3:0] s;
    logic       m;
    logic       cyin;
    logic [3:0] acc;
    logic [3:0] out;
    logic       hlt;
    logic       er;
  } vec_t;

  vec_t tv [64];
  int   nv = 0;

  task automatic add(input logic [3:0] afn, input logic cyo,
                     input logic [7:0] adr, input logic [9:0] gr,
                     input logic [9:0] sr, input logic [3:0] s,
                     input logic m, input logic cyin,
                     input logic [3:0] acc, input logic [3:0] out,
                     input logic hlt, input logic er);
    tv[nv] = '{afn, cyo, adr, gr, sr, s, m, cyin, acc, out, hlt, er};
    nv++;
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [7:0] wrap_exp [8];

  initial begin
    rst     = 1'b1;
    alu_f   = 4'h0;
    CYout   = 1'b1;
    IN_port = 4'hF;
`ifdef BURP_SEQ_STEP_EN
    step    = 1'b1;
`endif
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h15; rom[8'h01] = 8'h33;
    rom[8'h02] = 8'h19; rom[8'h03] = 8'h31;
    rom[8'h04] = 8'h18; rom[8'h05] = 8'h41;
    rom[8'h06] = 8'hD0; rom[8'h07] = 8'h0A;
    rom[8'h0A] = 8'h13; rom[8'h0B] = 8'h52;
    rom[8'h0C] = 8'hC0; rom[8'h0D] = 8'h20;
    rom[8'h20] = 8'hD0; rom[8'h21] = 8'h30;
    rom[8'h22] = 8'h90; rom[8'h23] = 8'hA0;
    rom[8'h24] = 8'h2C; rom[8'h25] = 8'h23;
    rom[8'h26] = 8'h65; rom[8'h27] = 8'h71;
    rom[8'h28] = 8'h81; rom[8'h29] = 8'hE0;
    rom[8'h2A] = 8'hF0;

    //  afn  cyo adr    gr      sr      s  m  cn acc out h  e
    add(0, 1, 8'h00, 10'h0, 10'h0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 8'h01, 10'h0, 10'h0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 8'h01, 10'h0, 10'h0, 0, 0, 1, 5, 0, 0, 0);
    add(0, 1, 8'h02, 10'h0, 10'h0, 0, 0, 1, 5, 0, 0, 0);
    add(0, 1, 8'h02, 10'h0, 10'h008, 0, 0, 1, 5, 0, 0, 0);
    add(0, 1, 8'h02, 10'h0, 10'h0, 0, 0, 1, 5, 0, 0, 0);
    add(0, 1, 8'h03, 10'h0, 10'h0, 0, 0, 1, 5, 0, 0, 0);
    add(0, 1, 8'h03, 10'h0, 10'h0, 0, 0, 1, 9, 0, 0, 0);
    add(0, 1, 8'h04, 10'h0, 10'h0, 0, 0, 1, 9, 0, 0, 0);
    add(0, 1, 8'h04, 10'h0, 10'h002, 0, 0, 1, 9, 0, 0, 0);
    add(0, 1, 8'h04, 10'h0, 10'h0, 0, 0, 1, 9, 0, 0, 0);
    add(0, 1, 8'h05, 10'h0, 10'h0, 0, 0, 1, 9, 0, 0, 0);
    add(0, 1, 8'h05, 10'h0, 10'h0, 0, 0, 1, 8, 0, 0, 0);
    add(1, 0, 8'h06, 10'h002, 10'h0, 4'h9, 0, 1, 8, 0, 0, 0);
    add(0, 1, 8'h06, 10'h0, 10'h0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 1, 8'h07, 10'h0, 10'h0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 1, 8'h08, 10'h0, 10'h0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 1, 8'h0A, 10'h0, 10'h0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 1, 8'h0B, 10'h0, 10'h0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 1, 8'h0B, 10'h0, 10'h0, 0, 0, 1, 3, 0, 0, 0);
    add(0, 1, 8'h0C, 10'h004, 10'h0, 4'h6, 0, 0, 3, 0, 0, 0);
    add(0, 1, 8'h0C, 10'h0, 10'h0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 8'h0D, 10'h0, 10'h0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 8'h0E, 10'h0, 10'h0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 8'h20, 10'h0, 10'h0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 8'h21, 10'h0, 10'h0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 8'h22, 10'h0, 10'h0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 8'h22, 10'h0, 10'h0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 8'h23, 10'h0, 10'h0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 8'h23, 10'h0, 10'h0, 0, 0, 1, 4'hF, 0, 0, 0);
    add(0, 1, 8'h24, 10'h0, 10'h0, 0, 0, 1, 4'hF, 0, 0, 0);
    add(0, 1, 8'h24, 10'h0, 10'h0, 0, 0, 1, 4'hF, 4'hF, 0, 0);
    add(7, 0, 8'h25, 10'h0, 10'h0, 0, 0, 1, 4'hF, 4'hF, 0, 0);
    add(0, 1, 8'h25, 10'h0, 10'h0, 0, 0, 1, 4'hF, 4'hF, 0, 1);
    add(5, 1, 8'h26, 10'h008, 10'h0, 4'hA, 1, 1, 4'hF, 4'hF, 0, 1);
    add(0, 1, 8'h26, 10'h0, 10'h0, 0, 0, 1, 5, 4'hF, 0, 1);
    add(0, 1, 8'h27, 10'h020, 10'h0, 4'hB, 1, 1, 5, 4'hF, 0, 1);
    add(0, 1, 8'h27, 10'h0, 10'h0, 0, 0, 1, 0, 4'hF, 0, 1);
    add(9, 1, 8'h28, 10'h002, 10'h0, 4'hE, 1, 1, 0, 4'hF, 0, 1);
    add(0, 1, 8'h28, 10'h0, 10'h0, 0, 0, 1, 9, 4'hF, 0, 1);
    add(0, 1, 8'h29, 10'h002, 10'h0, 4'h6, 1, 1, 9, 4'hF, 0, 1);
    add(0, 1, 8'h29, 10'h0, 10'h0, 0, 0, 1, 0, 4'hF, 0, 1);
    add(0, 1, 8'h2A, 10'h0, 10'h0, 0, 0, 1, 0, 4'hF, 0, 1);
    add(0, 1, 8'h2A, 10'h0, 10'h0, 0, 0, 1, 0, 4'hF, 0, 1);
    add(0, 1, 8'h2B, 10'h0, 10'h0, 0, 0, 1, 0, 4'hF, 1, 1);
    add(0, 1, 8'h2B, 10'h0, 10'h0, 0, 0, 1, 0, 4'hF, 1, 1);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < nv; i++) begin
      alu_f = tv[i].afn;
      CYout = tv[i].cyo;
      #1;
      chk("address", i, 16'(address), 16'(tv[i].adr));
      chk("Gr", i, 16'(Gr), 16'(tv[i].gr));
      chk("Sr", i, 16'(Sr), 16'(tv[i].sr));
      chk("S", i, 16'(S), 16'(tv[i].s));
      chk("Mode", i, 16'(Mode), 16'(tv[i].m));
      chk("CYin", i, 16'(CYin), 16'(tv[i].cyin));
      chk("acc", i, 16'(bus_a), 16'(tv[i].acc));
      chk("wb_data", i, 16'(wb_data), 16'(tv[i].acc));
      chk("OUT_wire", i, 16'(OUT_wire), 16'(tv[i].out));
      chk("halted", i, 16'(halted), 16'(tv[i].hlt));
      chk("err", i, 16'(err), 16'(tv[i].er));
      tick();
    end
    chk("r3_stored", 0, 16'(regs[3]), 16'h5);
    chk("r1_stored", 0, 16'(regs[1]), 16'h9);

    // Reset from a halted, errored state, then cut a STR during WB.
    alu_f = 4'h0;
    CYout = 1'b1;
    rom[8'h00] = 8'h17;
    do_reset();
    chk("rst_address", 0, 16'(address), 16'h00);
    chk("rst_acc", 0, 16'(bus_a), 16'h0);
    chk("rst_out", 0, 16'(OUT_wire), 16'h0);
    chk("rst_halted", 0, 16'(halted), 16'h0);
    chk("rst_err", 0, 16'(err), 16'h0);
    chk("rst_sel", 0, 16'(Gr | Sr), 16'h0);
    chk("rst_cyin", 0, 16'(CYin), 16'h1);
    repeat (4) tick();
    chk("wb_pre_sr", 0, 16'(Sr), 16'h008);
    chk("wb_pre_data", 0, 16'(wb_data), 16'h7);
    rst = 1'b1;
    #1;
    chk("wb_rst_sr", 0, 16'(Sr), 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("wb_rst_reg", 0, 16'(regs[3]), 16'h5);
    chk("wb_rst_addr", 0, 16'(address), 16'h00);
    chk("wb_rst_acc", 0, 16'(bus_a), 16'h0);
    chk("wb_rst_sr2", 0, 16'(Sr), 16'h0);
    chk("wb_rst_s", 0, 16'(S), 16'h0);

    // JMP FF, then a JMP at 0xFF whose operand comes from 0x00.
    rom[8'h00] = 8'hB0;
    rom[8'h01] = 8'hFF;
    rom[8'hFF] = 8'hB0;
    rom[8'hB0] = 8'hF0;
    wrap_exp = '{8'h00, 8'h01, 8'h02, 8'hFF,
                 8'h00, 8'h01, 8'hB0, 8'hB1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("wrap_addr", i, 16'(address), 16'(wrap_exp[i]));
      tick();
    end
    chk("wrap_halted", 0, 16'(halted), 16'h1);

`ifdef BURP_SEQ_STEP_EN
    rom[8'h00] = 8'h15;
    step = 1'b0;
    do_reset();
    repeat (20) tick();
    chk("step_hold_pc", 0, 16'(address), 16'h00);
    chk("step_hold_acc", 0, 16'(bus_a), 16'h0);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (6) tick();
    chk("step_one_pc", 0, 16'(address), 16'h01);
    chk("step_one_acc", 0, 16'(bus_a), 16'h5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
